// File: rtl/peripheral_bfm_axi4_pkg.sv
// Shared types and constants for the AXI4 peripheral BFM slave.
//   resp_t     : B/R response codes
//   burst_t    : AW burst encodings (reserved 2'b11 behaves as INCR)
//   wr_state_t : write-channel FSM states
//   rd_state_t : read-channel FSM states
//   wrap_len_ok: true for the burst lengths a WRAP burst may legally use
package peripheral_bfm_axi4_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/peripheral_bfm_axi4_addr_gen.sv
// Next-beat address calculator for one AXI channel.
//   addr      : address of the current beat
//   len/size/burst : latched burst attributes
//   next_addr : address of the following beat
//   wrap_err  : WRAP burst with an illegal length (stepped as INCR instead)
//   size_err  : beat size wider than the data bus
module peripheral_bfm_axi4_addr_gen
    import peripheral_bfm_axi4_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STRB_W = 4
)(
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              wrap_err,
    output logic              size_err
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] stepped;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        incr      = ADDR_W'(1) << size;
        stepped   = addr + incr;
        // Every legal wrap length gives a power-of-two window, so the
        // window can be handled as a mask rather than a modulo.
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        wrap_err  = (burst == BURST_WRAP) && !wrap_len_ok(len);
        size_err  = size > MAX_SIZE;

        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if ((burst == BURST_WRAP) && !wrap_err) begin
            next_addr = (addr & ~wrap_mask) | (stepped & wrap_mask);
        end else begin
            next_addr = stepped;
        end
    end

endmodule

// File: rtl/peripheral_bfm_slave_axi4.sv
// AXI4 (AXI3-style len/wid/lock) memory-model slave for the peripheral BFM bench.
// Accepts one write burst and one read burst at a time on independent paths and
// stores data in an internal word array (never cleared by reset).
//   aclk, aresetn        : clock; synchronous reset, active HIGH despite the name
//   aw* / awvalid/awready: write address channel
//   wid/wrdata/wstrb/wlast/wvalid/wready : write data channel
//   bid/bresp/bvalid/bready               : write response channel
//   ar* / arvalid/arready: read address channel (always INCR)
//   rid/rdata/rresp/rlast/rvalid/rready   : read data channel
module peripheral_bfm_slave_axi4
    import peripheral_bfm_axi4_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] MEM_BASE  = '0
)(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awadr,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic [1:0]            awlock,
    input  logic [3:0]            awcache,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_W-1:0]       wid,
    input  logic [DATA_W-1:0]     wrdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_W-1:0]       arid,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arlock,
    input  logic [3:0]            arcache,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int unsigned       STRB_W    = DATA_W / 8;
    localparam int unsigned       SHIFT     = $clog2(STRB_W);
    localparam int unsigned       IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * STRB_W);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= MEM_BASE) && ((a - MEM_BASE) < MEM_BYTES);
    endfunction

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // ---------------- write path ----------------
    wr_state_t         w_state, w_state_n;
    logic [ID_W-1:0]   w_id_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [3:0]        w_len_q;
    logic [2:0]        w_size_q;
    logic [1:0]        w_burst_q;
    logic [4:0]        w_beat_q;
    logic              w_err_q;
    logic [1:0]        bresp_q;

    logic [ADDR_W-1:0] w_next, w_off;
    logic [IDX_W-1:0]  w_idx;
    logic              w_wrap_err, w_size_err, w_in_range;
    logic              w_beat, w_beyond, w_beat_err, mem_we;

    peripheral_bfm_axi4_addr_gen #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_wr_addr (
        .addr      (w_addr_q),
        .len       (w_len_q),
        .size      (w_size_q),
        .burst     (w_burst_q),
        .next_addr (w_next),
        .wrap_err  (w_wrap_err),
        .size_err  (w_size_err)
    );

    always_comb begin
        w_state_n = w_state;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_state_n = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) w_state_n = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_comb begin
        w_off      = w_addr_q - MEM_BASE;
        w_idx      = w_off[SHIFT +: IDX_W];
        w_in_range = in_range(w_addr_q);
        w_beat     = wvalid && wready;
        // Beats past awlen+1 are dropped but the burst still waits for wlast.
        w_beyond   = w_beat_q > {1'b0, w_len_q};
        w_beat_err = w_beyond || !w_in_range || (wid != w_id_q) ||
                     (wlast && (w_beat_q != {1'b0, w_len_q})) ||
                     w_wrap_err || w_size_err;
        mem_we     = w_beat && !aresetn && !w_beyond && !w_size_err && w_in_range;
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            w_state   <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state <= w_state_n;
            if (awvalid && awready) begin
                w_id_q    <= awid;
                w_addr_q  <= awadr;
                w_len_q   <= awlen;
                w_size_q  <= awsize;
                w_burst_q <= awburst;
                w_beat_q  <= '0;
                w_err_q   <= 1'b0;
            end
            if (w_beat) begin
                w_addr_q <= w_next;
                if (w_beat_q != '1) w_beat_q <= w_beat_q + 5'd1;
                w_err_q <= w_err_q || w_beat_err;
                if (wlast) bresp_q <= (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wrdata[b*8 +: 8];
            end
        end
    end

    assign bid   = w_id_q;
    assign bresp = bresp_q;

    // ---------------- read path ----------------
    rd_state_t         r_state, r_state_n;
    logic [ID_W-1:0]   r_id_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [3:0]        r_len_q;
    logic [2:0]        r_size_q;
    logic [3:0]        r_beat_q;

    logic [ADDR_W-1:0] r_next, r_off;
    logic [IDX_W-1:0]  r_idx;
    logic              r_wrap_err, r_size_err, r_in_range, r_last;

    peripheral_bfm_axi4_addr_gen #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_rd_addr (
        .addr      (r_addr_q),
        .len       (r_len_q),
        .size      (r_size_q),
        .burst     (BURST_INCR),
        .next_addr (r_next),
        .wrap_err  (r_wrap_err),
        .size_err  (r_size_err)
    );

    always_comb begin
        r_state_n = r_state;
        arready   = 1'b0;
        rvalid    = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_state_n = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && r_last) r_state_n = R_IDLE;
            end
        endcase
    end

    // Array read is combinational: a write landing this cycle shows up next cycle.
    always_comb begin
        r_off      = r_addr_q - MEM_BASE;
        r_idx      = r_off[SHIFT +: IDX_W];
        r_in_range = in_range(r_addr_q);
        r_last     = r_beat_q == r_len_q;
        rlast      = rvalid && r_last;
        rresp      = (rvalid && (!r_in_range || r_size_err)) ? RESP_SLVERR : RESP_OKAY;
        rdata      = (rvalid && r_in_range) ? mem[r_idx] : '0;
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            r_state  <= R_IDLE;
            r_id_q   <= '0;
            r_addr_q <= '0;
            r_len_q  <= '0;
            r_size_q <= '0;
            r_beat_q <= '0;
        end else begin
            r_state <= r_state_n;
            if (arvalid && arready) begin
                r_id_q   <= arid;
                r_addr_q <= araddr;
                r_len_q  <= arlen;
                r_size_q <= arsize;
                r_beat_q <= '0;
            end
            if (rvalid && rready && !r_last) begin
                r_beat_q <= r_beat_q + 4'd1;
                r_addr_q <= r_next;
            end
        end
    end

    assign rid = r_id_q;

    logic unused_ok;
    assign unused_ok = ^{awlock, awcache, awprot, arlock, arcache, arprot,
                         w_off, r_off, r_wrap_err};

endmodule

// File: tb/tb_peripheral_bfm_slave_axi4.sv
module tb_peripheral_bfm_slave_axi4;

    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [31:0] MEM_END   = 32'(MEM_WORDS * 4);

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid;   logic [31:0] awadr;  logic [3:0] awlen;  logic [2:0] awsize;
    logic [1:0]  awburst; logic [1:0] awlock; logic [3:0] awcache; logic [2:0] awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;    logic [31:0] wrdata; logic [3:0] wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;    logic [1:0]  bresp;  logic bvalid, bready;
    logic [3:0]  arid;   logic [31:0] araddr; logic [3:0] arlen;  logic [2:0] arsize;
    logic [1:0]  arlock; logic [3:0]  arcache; logic [2:0] arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp;
    logic        rlast, rvalid, rready;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    logic [31:0] ref_mem [MEM_WORDS];

    always #5 aclk = ~aclk;

    peripheral_bfm_slave_axi4 #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_WORDS(MEM_WORDS), .MEM_BASE(32'h0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte address of beat i, from the burst rules written as plain arithmetic.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                              input int size, input int burst, input int i);
        int unsigned incr  = 1 << size;
        int unsigned total = (len + 1) * incr;
        logic [31:0] base;
        if (burst == 0) return a;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            base = (a / total) * total;
            return base + ((a - base) + i * incr) % total;
        end
        return a + i * incr;
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len,
                            input int size, input int burst, input int nbeats,
                            input logic [3:0] wid_v, input logic [31:0] dq[$], input logic [3:0] sq[$]);
        logic        err;
        logic        done;
        logic [31:0] ba, d;
        int          cnt;
        err = (size > 2) || (nbeats != len + 1) || (wid_v != id) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        awid = id; awadr = a; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
        awlock = 2'($urandom); awcache = 4'($urandom); awprot = 3'($urandom);
        awvalid = 1'b1;
        cnt = 0;
        while (awready !== 1'b1 && cnt < 50) begin @(posedge aclk); #1; cnt++; end
        check_eq("awready", 64'(awready), 64'(1));
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            while ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(posedge aclk); #1; end
            wid = wid_v; wrdata = dq[i]; wstrb = sq[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            cnt = 0;
            while (wready !== 1'b1 && cnt < 50) begin @(posedge aclk); #1; cnt++; end
            check_eq("wready", 64'(wready), 64'(1));
            @(posedge aclk); #1;
            ba = beat_addr(a, len, size, burst, i);
            if (i > len || ba >= MEM_END) begin
                err = 1'b1;
            end else if (size <= 2) begin
                d = ref_mem[ba[11:2]];
                for (int b = 0; b < 4; b++) if (sq[i][b]) d[8*b +: 8] = dq[i][8*b +: 8];
                ref_mem[ba[11:2]] = d;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            bready = 1'($urandom_range(0, 1));
            if (bvalid === 1'b1) begin
                check_eq("bid", 64'(bid), 64'(id));
                check_eq("bresp", 64'(bresp), err ? 64'(2) : 64'(0));
                if (bready) done = 1'b1;
            end
            @(posedge aclk); #1;
        end
        bready = 1'b0;
        check_eq("b_handshake", 64'(done), 64'(1));
        check_eq("bvalid_drop", 64'(bvalid), 64'(0));
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len,
                           input int size, output logic [31:0] got[$]);
        logic        done;
        logic [31:0] ba, exp_d;
        logic [1:0]  exp_r;
        int          cnt;
        got = {};
        arid = id; araddr = a; arlen = 4'(len); arsize = 3'(size);
        arlock = 2'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
        arvalid = 1'b1;
        cnt = 0;
        while (arready !== 1'b1 && cnt < 50) begin @(posedge aclk); #1; cnt++; end
        check_eq("arready", 64'(arready), 64'(1));
        @(posedge aclk); #1;
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            ba    = a + 32'(i) * (32'd1 << size);
            exp_d = (ba < MEM_END) ? ref_mem[ba[11:2]] : 32'h0;
            exp_r = (ba >= MEM_END || size > 2) ? 2'b10 : 2'b00;
            done  = 1'b0;
            for (int c = 0; c < 100 && !done; c++) begin
                rready = 1'($urandom_range(0, 1));
                if (rvalid === 1'b1) begin
                    check_eq("rdata", 64'(rdata), 64'(exp_d));
                    check_eq("rresp", 64'(rresp), 64'(exp_r));
                    check_eq("rlast", 64'(rlast), 64'(i == len));
                    check_eq("rid",   64'(rid),   64'(id));
                    if (rready) begin done = 1'b1; got.push_back(rdata); end
                end
                @(posedge aclk); #1;
            end
            rready = 1'b0;
            check_eq("r_beat", 64'(done), 64'(1));
        end
        check_eq("rvalid_drop", 64'(rvalid), 64'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] dq[$];
        logic [3:0]  sq[$];
        logic [31:0] got[$];
        logic [31:0] a;
        int          len, size, burst, nb, sel;
        logic [3:0]  id, widv;

        aresetn = 1'b1;
        awid = '0; awadr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0;
        awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wrdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arlock = '0; arcache = '0;
        arprot = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_eq("rst_awready", 64'(awready), 64'(1));
        check_eq("rst_arready", 64'(arready), 64'(1));
        check_eq("rst_wready",  64'(wready),  64'(0));
        check_eq("rst_bvalid",  64'(bvalid),  64'(0));
        check_eq("rst_rvalid",  64'(rvalid),  64'(0));
        check_eq("rst_rlast",   64'(rlast),   64'(0));
        check_eq("rst_ids",     64'({bid, rid}), 64'(0));
        check_eq("rst_resps",   64'({bresp, rresp}), 64'(0));
        check_eq("rst_rdata",   64'(rdata),   64'(0));
        aresetn = 1'b0;
        @(posedge aclk); #1;

        // Fill the whole array so every later read has a known expectation.
        for (int blk = 0; blk < 64; blk++) begin
            dq = {}; sq = {};
            for (int i = 0; i < 16; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
            do_write(4'(blk), 32'(blk * 64), 15, 2, 1, 16, 4'(blk), dq, sq);
        end

        // Single beat write then read back.
        do_write(4'd1, 32'h10, 0, 2, 1, 1, 4'd1, '{32'hDEADBEEF}, '{4'hF});
        do_read(4'd1, 32'h10, 0, 2, got);
        check_eq("single_rd", 64'(got[0]), 64'h0000_0000_DEAD_BEEF);

        // INCR 4-beat burst with id 5.
        do_write(4'd5, 32'h40, 3, 2, 1, 4, 4'd5, '{32'd1, 32'd2, 32'd3, 32'd4}, '{4'hF, 4'hF, 4'hF, 4'hF});
        do_read(4'd5, 32'h40, 3, 2, got);
        for (int i = 0; i < 4; i++) check_eq("incr_rd", 64'(got[i]), 64'(i + 1));

        // Partial strobes merge over existing data.
        do_write(4'd2, 32'h80, 0, 2, 1, 1, 4'd2, '{32'hFFFFFFFF}, '{4'hF});
        do_write(4'd2, 32'h80, 0, 2, 1, 1, 4'd2, '{32'hAAAA5555}, '{4'b0011});
        do_read(4'd2, 32'h80, 0, 2, got);
        check_eq("strb_rd", 64'(got[0]), 64'h0000_0000_FFFF_5555);

        // WRAP 4-beat burst starting mid-window.
        do_write(4'd3, 32'h38, 3, 2, 2, 4, 4'd3, '{32'hA, 32'hB, 32'hC, 32'hD}, '{4'hF, 4'hF, 4'hF, 4'hF});
        do_read(4'd3, 32'h30, 3, 2, got);
        check_eq("wrap_30", 64'(got[0]), 64'hC);
        check_eq("wrap_34", 64'(got[1]), 64'hD);
        check_eq("wrap_38", 64'(got[2]), 64'hA);
        check_eq("wrap_3c", 64'(got[3]), 64'hB);

        // Just past the end of the array, and the last legal word.
        do_write(4'd4, MEM_END, 0, 2, 1, 1, 4'd4, '{32'h12345678}, '{4'hF});
        do_read(4'd4, MEM_END, 0, 2, got);
        check_eq("oor_rd", 64'(got[0]), 64'h0);
        do_read(4'd4, MEM_END - 4, 1, 2, got);

        // Randomized mix of writes and reads, including error cases.
        for (int t = 0; t < 80; t++) begin
            id    = 4'($urandom);
            size  = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
            len   = int'($urandom_range(0, 15));
            a     = 32'($urandom_range(0, 32'(MEM_END) + 128)) & ~((32'd1 << size) - 1);
            if (t % 2 == 0) begin
                burst = int'($urandom_range(0, 3));
                sel   = int'($urandom_range(0, 9));
                nb    = (sel == 0 && len > 0) ? len : (sel == 1) ? len + 2 : len + 1;
                widv  = ($urandom_range(0, 9) == 0) ? (id ^ 4'd1) : id;
                dq = {}; sq = {};
                for (int i = 0; i < nb; i++) begin dq.push_back($urandom); sq.push_back(4'($urandom)); end
                do_write(id, a, len, size, burst, nb, widv, dq, sq);
            end else begin
                do_read(id, a, len, size, got);
            end
        end

        // Reset in the middle of a stalled read and a half-finished write.
        arid = 4'd7; araddr = 32'h100; arlen = 4'd7; arsize = 3'd2; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        awid = 4'd6; awadr = 32'h200; awlen = 4'd7; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wid = 4'd6; wrdata = $urandom; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            check_eq("rst_mid_wready", 64'(wready), 64'(1));
            @(posedge aclk); #1;
            ref_mem[(32'h200 >> 2) + i] = wrdata;
        end
        wvalid = 1'b0;
        check_eq("rst_mid_rvalid_pre", 64'(rvalid), 64'(1));
        aresetn = 1'b1;
        @(posedge aclk); #1;
        aresetn = 1'b0;
        check_eq("rst_mid_bvalid",  64'(bvalid),  64'(0));
        check_eq("rst_mid_rvalid",  64'(rvalid),  64'(0));
        check_eq("rst_mid_wready",  64'(wready),  64'(0));
        check_eq("rst_mid_awready", 64'(awready), 64'(1));
        check_eq("rst_mid_arready", 64'(arready), 64'(1));
        do_read(4'd8, 32'h200, 1, 2, got);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
